instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'h000, first fetch address after reset.
REQ-002 Parameter ADDR_W, default 12, byte-address width; matches the instruction memory read port.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Read_address  output  ADDR_W  byte address driven to the instruction memory; equals the PC register.
REQ-006 Instruction  input  32  little-endian word returned combinationally by the instruction memory for Read_address in the same cycle.
REQ-007 Redirect_valid  input  1  branch/jump taken; load PC from Redirect_target.
REQ-008 Redirect_target  input  ADDR_W  new fetch byte address.
REQ-009 Out_ready  input  1  decode stage accepts the current output this cycle.
REQ-010 Out_valid  output  1  Out_instr/Out_pc hold a valid fetched instruction.
REQ-011 Out_instr  output  32  fetched instruction word.
REQ-012 Out_pc  output  ADDR_W  byte address of Out_instr.
REQ-013 Out_pc_plus4  output  ADDR_W  Out_pc + 4, modulo 2**ADDR_W.
REQ-014 Fault  output  1  sticky misaligned-redirect indication.

Function
REQ-015 States: START, RUN, FAULT; encoded as an enum.
REQ-016 START: lasts exactly one cycle after reset deasserts, Out_valid=0, PC=RESET_PC; transitions to RUN.
REQ-017 RUN, output stage empty or (Out_valid && Out_ready): capture Instruction into Out_instr, PC into Out_pc, set Out_valid=1, PC <= PC+4.
REQ-018 RUN, Out_valid && !Out_ready: hold all output registers and PC unchanged (stall); Out_instr is not re-sampled.
REQ-019 Fetch latency: instruction at address A appears on Out_instr with Out_valid=1 one cycle after Read_address=A.
REQ-020 Handshake: a transfer occurs on a cycle where Out_valid && Out_ready; Out_valid never drops without a transfer except on redirect, fault or reset.
REQ-021 Redirect (Redirect_valid=1, target[1:0]==0) in RUN: next cycle PC=Redirect_target, Out_valid=0 (wrong-path instruction flushed, including a stalled one); redirect has priority over stall and over normal advance.
REQ-022 Redirect in START: honoured identically; PC takes target, state moves to RUN.
REQ-023 Redirect with target[1:0]!=0: next state FAULT, Out_valid=0, Fault=1; PC unchanged.
REQ-024 FAULT: Out_valid=0, Fault=1, PC frozen, all inputs ignored until reset.
REQ-025 PC arithmetic is modulo 2**ADDR_W: PC 12'hFFC advances to 12'h000 without flagging.
REQ-026 Out_pc_plus4 is combinational from Out_pc.

Reset
REQ-027 While reset=1 at a rising edge: state=START, PC=RESET_PC, Out_valid=0, Out_instr=32'h0, Out_pc=RESET_PC, Fault=0.
REQ-028 Reset overrides every other input, including Redirect_valid, in any state and mid-stall.

Structure
REQ-029 Shared package mips_pkg holds the state enum, ADDR_W default, and the PC increment constant (4).
REQ-030 Single module, no sub-module; the instruction memory is instantiated alongside it at the top level, not inside it.

Verification
REQ-031 Reset release, Out_ready=1, memory preloaded 0x11111111, 0x22222222 at 0,4 -> Out_valid first high 2 cycles after reset release; Out_pc=0 then 4 with matching words.
REQ-032 Out_ready=0 for 3 cycles while Out_pc=4 -> Read_address stays 8, Out_instr stays 0x22222222, then resumes with Out_pc=8.
REQ-033 Redirect_valid=1, target 12'h040 during a stall -> next cycle Out_valid=0, Read_address=12'h040; following cycle Out_pc=12'h040.
REQ-034 Redirect target 12'h0FE -> Fault=1, Out_valid=0 next cycle and held; reset clears Fault, restarts at RESET_PC.
REQ-035 Redirect to 12'hFFC, Out_ready=1 -> Out_pc sequence 12'hFFC, 12'h000; Out_pc_plus4 at 12'hFFC equals 12'h000.
REQ-036 Reset asserted simultaneously with Redirect_valid in RUN -> PC=RESET_PC, state START, redirect ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the fetch front end.
//   - fetch_state_t : fetch controller states (START, RUN, FAULT)
//   - ADDR_W_DEFAULT: default byte-address width of the instruction memory port
//   - PC_INC        : bytes per sequential instruction step
package mips_pkg;

    localparam int ADDR_W_DEFAULT = 12;
    localparam int PC_INC         = 4;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch
//   Single-stage instruction fetch. The PC drives an external combinational
//   instruction memory; the returned word is registered together with its
//   address into an output stage that feeds decode.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   reset           : synchronous, active-high reset
//   Read_address    : byte address to instruction memory (the PC register)
//   Instruction     : word returned by the memory for Read_address, same cycle
//   Redirect_valid  : taken branch/jump, load PC from Redirect_target
//   Redirect_target : new fetch byte address (must be word aligned)
//   Out_ready       : decode accepts the current output this cycle
//   Out_valid       : Out_instr/Out_pc hold a valid fetched instruction
//   Out_instr       : fetched instruction word
//   Out_pc          : byte address of Out_instr
//   Out_pc_plus4    : Out_pc + 4, wrapping at 2**ADDR_W
//   Fault           : sticky misaligned-redirect indication (cleared by reset)
//   dbg_state       : current controller state
//
// Handshake: the output stage follows valid/ready. A transfer happens on a
// cycle with Out_valid && Out_ready. While Out_valid is high and Out_ready is
// low, Out_instr/Out_pc and the PC are held; Out_valid only drops without a
// transfer on redirect, fault or reset.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] Read_address,
    input  logic [31:0]       Instruction,
    input  logic              Redirect_valid,
    input  logic [ADDR_W-1:0] Redirect_target,
    input  logic              Out_ready,
    output logic              Out_valid,
    output logic [31:0]       Out_instr,
    output logic [ADDR_W-1:0] Out_pc,
    output logic [ADDR_W-1:0] Out_pc_plus4,
    output logic              Fault,
    output fetch_state_t      dbg_state
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic              misaligned;

    assign misaligned = (Redirect_target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        case (state_q)
            START: begin
                state_d = RUN;
                valid_d = 1'b0;
                if (Redirect_valid) begin
                    if (misaligned) state_d = FAULT;
                    else            pc_d    = Redirect_target;
                end
            end
            RUN: begin
                if (Redirect_valid) begin
                    // Redirect wins over stall and advance; any held
                    // wrong-path instruction is dropped.
                    valid_d = 1'b0;
                    if (misaligned) state_d = FAULT;
                    else            pc_d    = Redirect_target;
                end else if (!valid_q || Out_ready) begin
                    instr_d = Instruction;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + ADDR_W'(PC_INC);
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = START;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            opc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign Read_address = pc_q;
    assign Out_valid    = valid_q;
    assign Out_instr    = instr_q;
    assign Out_pc       = opc_q;
    assign Out_pc_plus4 = opc_q + ADDR_W'(PC_INC);
    assign Fault        = (state_q == FAULT);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [11:0]  Read_address;
  logic [31:0]  Instruction;
  logic         Redirect_valid;
  logic [11:0]  Redirect_target;
  logic         Out_ready;
  logic         Out_valid;
  logic [31:0]  Out_instr;
  logic [11:0]  Out_pc;
  logic [11:0]  Out_pc_plus4;
  logic         Fault;
  fetch_state_t dbg_state;

  instr_fetch #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk             (clk),
    .reset           (reset),
    .Read_address    (Read_address),
    .Instruction     (Instruction),
    .Redirect_valid  (Redirect_valid),
    .Redirect_target (Redirect_target),
    .Out_ready       (Out_ready),
    .Out_valid       (Out_valid),
    .Out_instr       (Out_instr),
    .Out_pc          (Out_pc),
    .Out_pc_plus4    (Out_pc_plus4),
    .Fault           (Fault),
    .dbg_state       (dbg_state)
  );

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] word_at(input logic [11:0] a);
    if (a == 12'h000) return 32'h1111_1111;
    if (a == 12'h004) return 32'h2222_2222;
    return 32'hC000_0000 | {20'h0, a};
  endfunction

  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = word_at(12'(i * 4));
  end
  assign Instruction = mem[Read_address[11:2]];

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic rv, input logic [11:0] tgt, input logic rdy);
    reset = rst;
    Redirect_valid = rv;
    Redirect_target = tgt;
    Out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         rv;
    logic [11:0]  tgt;
    logic         rdy;
    logic         ev;
    logic [11:0]  epc;
    logic [31:0]  einstr;
    logic [11:0]  era;
    logic         efault;
    fetch_state_t est;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rv, input logic [11:0] tgt, input logic rdy,
                     input logic ev, input logic [11:0] epc, input logic [31:0] einstr,
                     input logic [11:0] era, input logic efault, input fetch_state_t est);
    vec_t v;
    v.rst = rst; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.era = era; v.efault = efault; v.est = est;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    logic v_pre;
    logic rdy_r;
    drive(1'b1, 1'b0, 12'h000, 1'b1);

    //   rst rv tgt     rdy  ev  epc     instr          ra      flt  state
    add(1, 0, 12'h000, 1,   0, 12'h000, 32'h0,         12'h000, 0, START); // reset state
    add(1, 0, 12'h000, 1,   0, 12'h000, 32'h0,         12'h000, 0, START);
    add(0, 0, 12'h000, 1,   0, 12'h000, 32'h0,         12'h000, 0, RUN);   // START lasts one cycle
    add(0, 0, 12'h000, 1,   1, 12'h000, 32'h1111_1111, 12'h004, 0, RUN);
    add(0, 0, 12'h000, 1,   1, 12'h004, 32'h2222_2222, 12'h008, 0, RUN);
    add(0, 0, 12'h000, 0,   1, 12'h004, 32'h2222_2222, 12'h008, 0, RUN);   // stall x3
    add(0, 0, 12'h000, 0,   1, 12'h004, 32'h2222_2222, 12'h008, 0, RUN);
    add(0, 0, 12'h000, 0,   1, 12'h004, 32'h2222_2222, 12'h008, 0, RUN);
    add(0, 0, 12'h000, 1,   1, 12'h008, 32'hC000_0008, 12'h00C, 0, RUN);   // resume
    add(0, 0, 12'h000, 0,   1, 12'h008, 32'hC000_0008, 12'h00C, 0, RUN);   // stall
    add(0, 1, 12'h040, 0,   0, 12'h008, 32'hC000_0008, 12'h040, 0, RUN);   // redirect during stall
    add(0, 0, 12'h000, 1,   1, 12'h040, 32'hC000_0040, 12'h044, 0, RUN);
    add(0, 1, 12'hFFC, 1,   0, 12'h040, 32'hC000_0040, 12'hFFC, 0, RUN);   // redirect to top
    add(0, 0, 12'h000, 1,   1, 12'hFFC, 32'hC000_0FFC, 12'h000, 0, RUN);   // wrap
    add(0, 0, 12'h000, 1,   1, 12'h000, 32'h1111_1111, 12'h004, 0, RUN);
    add(1, 1, 12'h080, 1,   0, 12'h000, 32'h0,         12'h000, 0, START); // reset beats redirect
    add(0, 1, 12'h100, 1,   0, 12'h000, 32'h0,         12'h100, 0, RUN);   // redirect in START
    add(0, 0, 12'h000, 1,   1, 12'h100, 32'hC000_0100, 12'h104, 0, RUN);
    add(0, 1, 12'h0FE, 0,   0, 12'h100, 32'hC000_0100, 12'h104, 1, FAULT); // misaligned
    add(0, 1, 12'h040, 1,   0, 12'h100, 32'hC000_0100, 12'h104, 1, FAULT); // inputs ignored
    add(0, 0, 12'h000, 1,   0, 12'h100, 32'hC000_0100, 12'h104, 1, FAULT);
    add(1, 0, 12'h000, 1,   0, 12'h000, 32'h0,         12'h000, 0, START); // reset clears fault
    add(0, 0, 12'h000, 1,   0, 12'h000, 32'h0,         12'h000, 0, RUN);
    add(0, 0, 12'h000, 1,   1, 12'h000, 32'h1111_1111, 12'h004, 0, RUN);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].tgt, vecs[i].rdy);
      step();
      chk($sformatf("v%0d out_valid", i),    {31'h0, Out_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("v%0d out_pc", i),       {20'h0, Out_pc}, {20'h0, vecs[i].epc});
      chk($sformatf("v%0d out_pc_plus4", i), {20'h0, Out_pc_plus4}, {20'h0, 12'(vecs[i].epc + 12'd4)});
      chk($sformatf("v%0d out_instr", i),    Out_instr, vecs[i].einstr);
      chk($sformatf("v%0d read_address", i), {20'h0, Read_address}, {20'h0, vecs[i].era});
      chk($sformatf("v%0d fault", i),        {31'h0, Fault}, {31'h0, vecs[i].efault});
      chk($sformatf("v%0d state", i),        {30'h0, dbg_state}, {30'h0, vecs[i].est});
    end

    // ---- latency from reset release to first Out_valid (bounded wait) ----
    drive(1'b1, 1'b0, 12'h000, 1'b1);
    step();
    drive(1'b0, 1'b0, 12'h000, 1'b1);
    n = 0;
    while (!Out_valid && n < 8) begin
      step();
      n++;
    end
    chk("first_valid_latency", n, 2);

    // ---- random back-pressure stream against the expected address queue ----
    drive(1'b1, 1'b0, 12'h000, 1'b0);
    step();
    drive(1'b0, 1'b0, 12'h000, 1'b0);
    step();
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(12'(k * 4));
    for (int c = 0; c < 48; c++) begin
      rdy_r = 1'($urandom_range(0, 1));
      Out_ready = rdy_r;
      v_pre = Out_valid;
      if (v_pre && rdy_r) begin
        chk($sformatf("sb%0d xfer_pc", c), {20'h0, Out_pc}, {20'h0, exp_q[0]});
        chk($sformatf("sb%0d xfer_instr", c), Out_instr, word_at(exp_q[0]));
        void'(exp_q.pop_front());
      end
      step();
      if (v_pre && !rdy_r) begin
        chk($sformatf("sb%0d stall_valid", c), {31'h0, Out_valid}, 32'h1);
        chk($sformatf("sb%0d stall_pc", c), {20'h0, Out_pc}, {20'h0, exp_q[0]});
      end
    end

    // ---- fault is sticky under random inputs ----
    drive(1'b1, 1'b0, 12'h000, 1'b1);
    step();
    drive(1'b0, 1'b0, 12'h000, 1'b1);
    step();
    drive(1'b0, 1'b1, 12'h0FE, 1'b1);
    step();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 1023) * 4), 1'($urandom_range(0, 1)));
      step();
      chk($sformatf("flt%0d fault", c), {31'h0, Fault}, 32'h1);
      chk($sformatf("flt%0d out_valid", c), {31'h0, Out_valid}, 32'h0);
      chk($sformatf("flt%0d read_address", c), {20'h0, Read_address}, 32'h0);
    end

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
